hax_floor_request_scheduler: RTL and testbench

- Upstream stage of the elevator controller.
- Latches floor-request pulses (from the SW/KEY[3] front end) into a pending-request bitmap.
- Picks the next destination using a SCAN (sweep) policy and hands one target at a time to the controller over a valid/ready handshake.
- Clears each request once the controller reports arrival at that floor.

---
 rtl/hax_floor_request_scheduler.sv | 125 ++++++++++++
 tb/tb_hax_floor_request_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hax_floor_request_scheduler.sv
// Floor-request scheduler: latches request pulses into a pending bitmap and offers
// one destination at a time to the elevator controller using a SCAN sweep policy.
module hax_floor_request_scheduler #(
  parameter int unsigned NUM_FLOORS = 10,
  parameter int unsigned FLOOR_W    = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic                  target_valid,
  output logic [FLOOR_W-1:0]    target_floor,
  input  logic                  target_ready,
  input  logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  req_dropped
);

  typedef enum logic [1:0] {StIdle, StSelect, StOffer, StWaitArrive} state_e;

  state_e state;

  logic [NUM_FLOORS-1:0] req_mask;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [NUM_FLOORS-1:0] pending_next;
  logic                  drop;

  // A request matching the floor being cleared this cycle is satisfied, not dropped.
  always_comb begin
    req_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      req_mask[i] = req_valid && (req_floor == FLOOR_W'(i));
      clr_mask[i] = (state == StWaitArrive) && arrived && (target_floor == FLOOR_W'(i));
    end
    pending_next = (pending | req_mask) & ~clr_mask;
    drop = req_valid && (!(|req_mask) || (|(req_mask & pending & ~clr_mask)));
  end

  logic               hit;
  logic               up_found;
  logic               down_found;
  logic [FLOOR_W-1:0] up_sel;
  logic [FLOOR_W-1:0] down_sel;
  logic [FLOOR_W-1:0] sel_floor;
  logic               sel_dir;

  always_comb begin
    hit        = 1'b0;
    up_found   = 1'b0;
    down_found = 1'b0;
    up_sel     = '0;
    down_sel   = '0;
    // Descending scan keeps the lowest floor above; ascending keeps the highest below.
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
        up_found = 1'b1;
        up_sel   = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
        down_found = 1'b1;
        down_sel   = FLOOR_W'(i);
      end
      if (pending[i] && (FLOOR_W'(i) == cur_floor)) begin
        hit = 1'b1;
      end
    end

    sel_floor = target_floor;
    sel_dir   = dir_up;
    if (hit) begin
      sel_floor = cur_floor;
    end else if (dir_up && up_found) begin
      sel_floor = up_sel;
    end else if (!dir_up && down_found) begin
      sel_floor = down_sel;
    end else if (up_found) begin
      sel_floor = up_sel;
      sel_dir   = 1'b1;
    end else if (down_found) begin
      sel_floor = down_sel;
      sel_dir   = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= StIdle;
      pending      <= '0;
      target_valid <= 1'b0;
      target_floor <= '0;
      dir_up       <= 1'b1;
      req_dropped  <= 1'b0;
    end else begin
      pending     <= pending_next;
      req_dropped <= drop;
      unique case (state)
        StIdle: begin
          if (|pending) state <= StSelect;
        end
        StSelect: begin
          target_floor <= sel_floor;
          dir_up       <= sel_dir;
          target_valid <= 1'b1;
          state        <= StOffer;
        end
        StOffer: begin
          if (target_ready) begin
            target_valid <= 1'b0;
            state        <= StWaitArrive;
          end
        end
        StWaitArrive: begin
          if (arrived) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hax_floor_request_scheduler.sv
// Directed bench for hax_floor_request_scheduler: a per-cycle vector table followed
// by hand-written SCAN ordering, back-pressure, arrival/request collision and reset cases.
module tb_hax_floor_request_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_floor = '0;
  logic [3:0] cur_floor = '0;
  logic       target_valid;
  logic [3:0] target_floor;
  logic       target_ready = 1'b0;
  logic       arrived = 1'b0;
  logic [9:0] pending;
  logic       dir_up;
  logic       req_dropped;

  int passed = 0;
  int total  = 0;

  hax_floor_request_scheduler #(.NUM_FLOORS(10), .FLOOR_W(4)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .cur_floor    (cur_floor),
    .target_valid (target_valid),
    .target_floor (target_floor),
    .target_ready (target_ready),
    .arrived      (arrived),
    .pending      (pending),
    .dir_up       (dir_up),
    .req_dropped  (req_dropped)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       rst;
    logic       rv;
    logic [3:0] rf;
    logic [3:0] cf;
    logic       rdy;
    logic       arr;
    logic [9:0] pend;
    logic       tv;
    logic [3:0] tf;
    logic       dir;
    logic       drop;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic request(input logic [3:0] f);
    req_valid = 1'b1;
    req_floor = f;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_offer();
    int n = 0;
    while (!target_valid && n < 8) begin
      step();
      n++;
    end
    check("offer_timeout", {31'd0, target_valid}, 32'd1);
  endtask

  task automatic accept();
    target_ready = 1'b1;
    step();
    target_ready = 1'b0;
  endtask

  task automatic arrive();
    arrived = 1'b1;
    step();
    arrived = 1'b0;
  endtask

  logic [3:0] scan_tf  [3];
  logic       scan_dir [3];

  initial begin
    //          rst   rv    rf     cf     rdy   arr   pend      tv    tf     dir   drop
    vecs[0]  = '{1'b1, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 10'h000, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd7,  4'd0, 1'b1, 1'b0, 10'h080, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 10'h080, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 10'h080, 1'b1, 4'd7, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 10'h080, 1'b0, 4'd7, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  4'd7, 1'b0, 1'b1, 10'h000, 1'b0, 4'd7, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 10'h000, 1'b0, 4'd7, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd12, 4'd0, 1'b0, 1'b0, 10'h000, 1'b0, 4'd7, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 4'd4,  4'd0, 1'b0, 1'b0, 10'h010, 1'b0, 4'd7, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'd4,  4'd0, 1'b0, 1'b0, 10'h010, 1'b0, 4'd7, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 10'h010, 1'b1, 4'd4, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 10'h010, 1'b1, 4'd4, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 10'h010, 1'b0, 4'd4, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'd4,  4'd4, 1'b0, 1'b1, 10'h000, 1'b0, 4'd4, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 4'd0,  4'd4, 1'b0, 1'b0, 10'h000, 1'b0, 4'd4, 1'b1, 1'b0};

    step();
    step();
    for (int i = 0; i < 15; i++) begin
      reset        = vecs[i].rst;
      req_valid    = vecs[i].rv;
      req_floor    = vecs[i].rf;
      cur_floor    = vecs[i].cf;
      target_ready = vecs[i].rdy;
      arrived      = vecs[i].arr;
      step();
      check($sformatf("vec%0d_pending", i), {22'd0, pending}, {22'd0, vecs[i].pend});
      check($sformatf("vec%0d_tvalid", i), {31'd0, target_valid}, {31'd0, vecs[i].tv});
      check($sformatf("vec%0d_tfloor", i), {28'd0, target_floor}, {28'd0, vecs[i].tf});
      check($sformatf("vec%0d_dir", i), {31'd0, dir_up}, {31'd0, vecs[i].dir});
      check($sformatf("vec%0d_drop", i), {31'd0, req_dropped}, {31'd0, vecs[i].drop});
    end
    req_valid = 1'b0;
    target_ready = 1'b0;
    arrived = 1'b0;

    // SCAN order from floor 5 heading up with {2,8,6} pending: 6, 8, then reverse to 2.
    cur_floor = 4'd5;
    request(4'd5);
    wait_offer();
    check("scan_first_hit", {28'd0, target_floor}, 32'd5);
    accept();
    request(4'd2);
    request(4'd8);
    request(4'd6);
    arrive();
    check("scan_pending", {22'd0, pending}, 32'h144);
    scan_tf[0] = 4'd6; scan_dir[0] = 1'b1;
    scan_tf[1] = 4'd8; scan_dir[1] = 1'b1;
    scan_tf[2] = 4'd2; scan_dir[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_offer();
      check($sformatf("scan%0d_floor", k), {28'd0, target_floor}, {28'd0, scan_tf[k]});
      check($sformatf("scan%0d_dir", k), {31'd0, dir_up}, {31'd0, scan_dir[k]});
      accept();
      cur_floor = scan_tf[k];
      arrive();
    end
    check("scan_empty", {22'd0, pending}, 32'd0);

    // Back-pressure: offer for 7 must hold while a new request for 3 is captured.
    cur_floor = 4'd0;
    request(4'd7);
    wait_offer();
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        req_valid = 1'b1;
        req_floor = 4'd3;
      end
      step();
      req_valid = 1'b0;
      check("hold_tvalid", {31'd0, target_valid}, 32'd1);
      check("hold_tfloor", {28'd0, target_floor}, 32'd7);
    end
    check("hold_pending", {22'd0, pending}, 32'h088);
    accept();
    cur_floor = 4'd7;
    arrive();
    wait_offer();
    check("after_hold_floor", {28'd0, target_floor}, 32'd3);
    check("after_hold_dir", {31'd0, dir_up}, 32'd0);
    accept();
    cur_floor = 4'd3;
    arrive();

    // Arrival at 4 collides with a new request for 4 while 1 is also pending.
    request(4'd4);
    wait_offer();
    check("coll_floor", {28'd0, target_floor}, 32'd4);
    accept();
    request(4'd1);
    cur_floor = 4'd4;
    req_valid = 1'b1;
    req_floor = 4'd4;
    arrived = 1'b1;
    step();
    req_valid = 1'b0;
    arrived = 1'b0;
    check("coll_pending", {22'd0, pending}, 32'h002);
    check("coll_drop", {31'd0, req_dropped}, 32'd0);
    wait_offer();
    check("coll_next_floor", {28'd0, target_floor}, 32'd1);
    check("coll_next_dir", {31'd0, dir_up}, 32'd0);
    accept();
    cur_floor = 4'd1;
    arrive();

    // Reset during an offer abandons it; a stray arrival afterwards is ignored.
    cur_floor = 4'd5;
    request(4'd3);
    request(4'd9);
    wait_offer();
    check("rst_pre_pending", {22'd0, pending}, 32'h208);
    check("rst_pre_dir", {31'd0, dir_up}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_tvalid", {31'd0, target_valid}, 32'd0);
    check("rst_pending", {22'd0, pending}, 32'd0);
    check("rst_dir", {31'd0, dir_up}, 32'd1);
    check("rst_tfloor", {28'd0, target_floor}, 32'd0);
    arrive();
    step();
    step();
    check("rst_arr_pending", {22'd0, pending}, 32'd0);
    check("rst_arr_tvalid", {31'd0, target_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
